audio_play_buf: RTL and testbench

AUDIO_PLAY_BUF -- requirements
Module: audio_play_buf

---
 rtl/audio_play_buf.sv | 126 ++++++++++++
 tb/tb_audio_play_buf.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_play_buf.sv
// Playback buffer between a user sample source and the DAC serializer.
// A circular FIFO fills in PREFILL and drains one word per tx_done in PLAY.
module audio_play_buf #(
    parameter int WL     = 32,
    parameter int AW     = 4,
    parameter int THRESH = 8
) (
    input  logic          aud_bclk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [WL-1:0] wr_data,
    output logic          wr_full,
    input  logic          tx_done,
    output logic [WL-1:0] dac_data,
    output logic [AW:0]   fifo_level,
    output logic          playing,
    output logic          underrun,
    output logic          overflow
);

    // state   | meaning
    // PREFILL | filling, output muted, tx_done ignored
    // PLAY    | one word popped per tx_done; empty pop returns to PREFILL
    typedef enum logic {
        PREFILL = 1'b0,
        PLAY    = 1'b1
    } state_t;

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_L = (AW+1)'(THRESH);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [WL-1:0]   dac_q, dac_d;
    logic            playing_q, playing_d;
    logic            underrun_q, underrun_d;
    logic            overflow_q, overflow_d;
    logic [WL-1:0]   mem [DEPTH];

    logic full, empty, wr_acc, pop, pop_fail;

    always_comb begin
        full     = (level_q == DEPTH_L);
        empty    = (level_q == '0);
        // Fullness is judged on the current level, so a same-cycle pop cannot rescue a write.
        wr_acc   = wr_en && !full;
        pop      = (state_q == PLAY) && tx_done && !empty;
        pop_fail = (state_q == PLAY) && tx_done && empty;

        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        if (wr_acc && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!wr_acc && pop) begin
            level_d = level_q - 1'b1;
        end

        state_d = state_q;
        dac_d   = dac_q;
        case (state_q)
            PREFILL: begin
                dac_d = '0;
                if (level_q >= THRESH_L) begin
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (pop) begin
                    dac_d = mem[rd_ptr_q];
                end else if (pop_fail) begin
                    dac_d   = '0;
                    state_d = PREFILL;
                end
            end
            default: begin
                dac_d   = '0;
                state_d = PREFILL;
            end
        endcase

        playing_d  = (state_d == PLAY);
        underrun_d = pop_fail;
        overflow_d = wr_en && full;
    end

    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PREFILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            dac_q      <= '0;
            playing_q  <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            dac_q      <= dac_d;
            playing_q  <= playing_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge aud_bclk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_full    = full;
    assign dac_data   = dac_q;
    assign fifo_level = level_q;
    assign playing    = playing_q;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_audio_play_buf.sv
// Bench for audio_play_buf: fixed vector table, directed corner sequences,
// and random traffic against a queue-based playback model.
module tb_audio_play_buf;

    localparam int WL     = 32;
    localparam int AW     = 4;
    localparam int THRESH = 8;
    localparam int DEPTH  = 16;

    logic          aud_bclk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [WL-1:0] wr_data;
    logic          wr_full;
    logic          tx_done;
    logic [WL-1:0] dac_data;
    logic [AW:0]   fifo_level;
    logic          playing;
    logic          underrun;
    logic          overflow;

    audio_play_buf #(.WL(WL), .AW(AW), .THRESH(THRESH)) dut (
        .aud_bclk   (aud_bclk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_full    (wr_full),
        .tx_done    (tx_done),
        .dac_data   (dac_data),
        .fifo_level (fifo_level),
        .playing    (playing),
        .underrun   (underrun),
        .overflow   (overflow)
    );

    always #5 aud_bclk = ~aud_bclk;

    int errors = 0;
    int checks = 0;

    // Reference model: the buffered words as a queue plus the playback flag.
    logic [WL-1:0] mq[$];
    bit            m_play;
    logic [WL-1:0] m_dac;
    bit            m_under;
    bit            m_over;

    typedef struct packed {
        logic          we;
        logic [WL-1:0] wd;
        logic          td;
        logic [AW:0]   lvl;
        logic          ply;
        logic [WL-1:0] dac;
        logic          und;
        logic          ovf;
    } vec_t;

    vec_t vt[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_play  = 0;
        m_dac   = '0;
        m_under = 0;
        m_over  = 0;
    endtask

    task automatic model_step(input logic we, input logic [WL-1:0] wd, input logic td);
        int n;
        bit was_play;
        bit is_full;
        n        = mq.size();
        was_play = m_play;
        is_full  = (n == DEPTH);
        m_over   = we && is_full;
        m_under  = was_play && td && (n == 0);
        if (!was_play) begin
            m_dac = '0;
            if (n >= THRESH) m_play = 1;
        end else if (td) begin
            if (n > 0) begin
                m_dac = mq.pop_front();
            end else begin
                m_dac  = '0;
                m_play = 0;
            end
        end
        if (we && !is_full) mq.push_back(wd);
    endtask

    // Called at a falling edge; applies one cycle of stimulus and compares with the model.
    task automatic cycle(input logic we, input logic [WL-1:0] wd, input logic td);
        wr_en   = we;
        wr_data = wd;
        tx_done = td;
        #1;
        chk("wr_full", 32'(wr_full), 32'(mq.size() == DEPTH));
        @(posedge aud_bclk);
        model_step(we, wd, td);
        #1;
        chk("dac_data", dac_data, m_dac);
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("playing", 32'(playing), 32'(m_play));
        chk("underrun", 32'(underrun), 32'(m_under));
        chk("overflow", 32'(overflow), 32'(m_over));
        @(negedge aud_bclk);
    endtask

    task automatic do_reset();
        wr_en   = 1'b0;
        wr_data = '0;
        tx_done = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        repeat (2) @(negedge aud_bclk);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic we, input logic [WL-1:0] wd, input logic td,
                                input int lvl, input logic ply, input logic [WL-1:0] dac,
                                input logic und);
        vec_t v;
        v.we  = we;
        v.wd  = wd;
        v.td  = td;
        v.lvl = (AW+1)'(lvl);
        v.ply = ply;
        v.dac = dac;
        v.und = und;
        v.ovf = 1'b0;
        return v;
    endfunction

    initial begin
        logic [WL-1:0] base;
        base = 32'h1111_1111;

        // Prefill 7, ignored tx_done, 8th word, one idle edge to enter PLAY,
        // eight pops, hold, underrun, ignored tx_done, idle.
        for (int k = 1; k <= 7; k++) vt[k-1] = mk(1, base * 32'(k), 0, k, 0, '0, 0);
        vt[7]  = mk(0, '0, 1, 7, 0, '0, 0);
        vt[8]  = mk(1, base * 32'd8, 0, 8, 0, '0, 0);
        vt[9]  = mk(0, '0, 0, 8, 1, '0, 0);
        for (int k = 1; k <= 8; k++) vt[9+k] = mk(0, '0, 1, 8 - k, 1, base * 32'(k), 0);
        vt[18] = mk(0, '0, 0, 0, 1, 32'h8888_8888, 0);
        vt[19] = mk(0, '0, 1, 0, 0, '0, 1);
        vt[20] = mk(0, '0, 1, 0, 0, '0, 0);
        vt[21] = mk(0, '0, 0, 0, 0, '0, 0);

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        tx_done = 1'b0;
        model_reset();
        #1;
        chk("rst_dac", dac_data, '0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_wr_full", 32'(wr_full), 0);
        do_reset();

        for (int i = 0; i < 22; i++) begin
            cycle(vt[i].we, vt[i].wd, vt[i].td);
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vt[i].lvl));
            chk($sformatf("vec%0d_playing", i), 32'(playing), 32'(vt[i].ply));
            chk($sformatf("vec%0d_dac", i), dac_data, vt[i].dac);
            chk($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(vt[i].und));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vt[i].ovf));
        end

        // Seventeen writes with no pops: last one dropped, then drain in order.
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            cycle(1, 32'hA000_0000 + 32'(k), 0);
            if (k == 15) chk("not_full_at_15", 32'(wr_full), 0);
            if (k == 16) chk("full_after_16", 32'(wr_full), 1);
        end
        chk("drop17_overflow", 32'(overflow), 1);
        chk("drop17_level", 32'(fifo_level), 16);
        cycle(0, '0, 0);
        chk("overflow_one_cycle", 32'(overflow), 0);
        for (int k = 1; k <= 16; k++) begin
            cycle(0, '0, 1);
            chk($sformatf("pop_order%0d", k), dac_data, 32'hA000_0000 + 32'(k));
        end

        // Empty in PLAY with a write and tx_done together.
        chk("empty_still_playing", 32'(playing), 1);
        cycle(1, 32'hBEEF_0001, 1);
        chk("wr_pop_empty_underrun", 32'(underrun), 1);
        chk("wr_pop_empty_level", 32'(fifo_level), 1);
        chk("wr_pop_empty_playing", 32'(playing), 0);

        // Full FIFO with write and pop together: write dropped, level drops.
        for (int k = 2; k <= 16; k++) cycle(1, 32'hBEEF_0000 + 32'(k), 0);
        chk("refill_level", 32'(fifo_level), 16);
        cycle(1, 32'hDEAD_DEAD, 1);
        chk("full_wr_pop_overflow", 32'(overflow), 1);
        chk("full_wr_pop_level", 32'(fifo_level), 15);
        chk("full_wr_pop_dac", dac_data, 32'hBEEF_0001);

        // Reset in PLAY with five words buffered.
        repeat (10) cycle(0, '0, 1);
        chk("pre_reset_level", 32'(fifo_level), 5);
        chk("pre_reset_playing", 32'(playing), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_dac", dac_data, '0);
        chk("async_rst_level", 32'(fifo_level), 0);
        chk("async_rst_playing", 32'(playing), 0);
        chk("async_rst_underrun", 32'(underrun), 0);
        chk("async_rst_overflow", 32'(overflow), 0);
        model_reset();
        @(negedge aud_bclk);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) cycle(1, 32'h5500_0000 + 32'(k), 0);
        cycle(0, '0, 1);
        chk("post_rst_7_playing", 32'(playing), 0);
        cycle(1, 32'h5500_0008, 0);
        chk("post_rst_8th_edge", 32'(playing), 0);
        cycle(0, '0, 0);
        chk("post_rst_play", 32'(playing), 1);
        cycle(0, '0, 1);
        chk("post_rst_first_word", dac_data, 32'h5500_0001);

        // Random traffic in phases that push toward full, toward empty, and mixed.
        for (int ph = 0; ph < 4; ph++) begin
            int pw;
            int pt;
            pw = (ph == 0) ? 85 : (ph == 1) ? 20 : (ph == 2) ? 50 : 60;
            pt = (ph == 0) ? 15 : (ph == 1) ? 80 : (ph == 2) ? 50 : 35;
            for (int c = 0; c < 500; c++) begin
                cycle(($urandom_range(99) < pw) ? 1'b1 : 1'b0, $urandom,
                      ($urandom_range(99) < pt) ? 1'b1 : 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
